frame_buffer_reader: RTL
========================

Name: frame_buffer_reader

Overview:
- AXI4 read-master DMA: fetches one frame of packed 24-bit RGB from DDR and emits it as a pixel stream for the display/DSI path.
- Inverse of the HDMI capture writer: reads the same little-endian byte stream (4 pixels per 3 words) and unpacks it.
- Credit-based burst issue into an internal word FIFO; single clock domain.

Parameters:
- BURST_SIZE, 128, words per full INCR burst; power of 2, 2..256; BURST_SIZE*4 <= 4096.
- MAX_OUTSTANDING_TR, 2, maximum AR bursts in flight.
- FIFO_DEPTH, 512, internal word FIFO depth; power of 2, >= BURST_SIZE*MAX_OUTSTANDING_TR.

Ports:
- clk_sys  in  1  system clock; sole clock.
- rst_sys  in  1  async active-high reset.
- cfg_enable  in  1  DMA enable level.
- cfg_start_addr  in  32  frame base byte address; aligned to BURST_SIZE*4.
- cfg_pixel_number  in  26  pixels per frame; nonzero multiple of 4.
- frame_start  in  1  one-cycle pulse that starts a frame.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- rresp_err  out  1  sticky; set when rresp != 0; cleared by frame_start.
- mst_axi_arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  read address channel.
- mst_axi_arvalid  out  1  read address valid.
- mst_axi_arready  in  1  read address ready.
- mst_axi_rdata  in  32  read data.
- mst_axi_rresp  in  2  read response.
- mst_axi_rlast  in  1  last beat of burst.
- mst_axi_rvalid  in  1  read data valid.
- mst_axi_rready  out  1  read data ready.
- pix_data  out  24  pixel {R,G,B}, byte0 in [7:0].
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  qualifies first pixel of frame.
- pix_eof  out  1  qualifies last pixel of frame.

Behaviour:
- Reset values: all outputs 0. Constant AXI fields: arid=0, arsize=3'b010, arburst=2'b01. mst_axi_rready=1 outside reset.
- Frame start: frame_start && cfg_enable in IDLE latches base address, total_words = cfg_pixel_number*3/4 (27-bit), and pixel count. Next state is FETCH. frame_start is ignored when not in IDLE.
- States and transitions:
  - IDLE -> FETCH on frame start.
  - FETCH -> DRAIN when words_left == 0 after an AR handshake.
  - DRAIN -> IDLE when every pixel has been accepted; frame_done pulses for one cycle on that transition.
  - FETCH/DRAIN -> FLUSH when cfg_enable drops.
  - FLUSH -> IDLE once outstanding == 0. Read data in FLUSH is discarded, FIFO and unpacker are cleared, and no frame_done is issued.
- AR issue condition: FETCH && outstanding < MAX_OUTSTANDING_TR && (FIFO_DEPTH - fifo_count - reserved) >= BURST_SIZE. reserved = words promised to in-flight bursts but not yet received.
- arlen = min(words_left, BURST_SIZE) - 1, so the final burst may be short.
- arvalid and araddr/arlen hold stable until arready. On handshake: araddr += (arlen+1)*4, words_left -= arlen+1, outstanding += 1, reserved += arlen+1.
- R channel: every beat with rvalid is written to the FIFO (rready=1 is safe because credits guarantee space). Each beat decrements reserved.
- rvalid && rlast decrements outstanding; a simultaneous AR handshake leaves outstanding unchanged.
- Unpack from 3-word group w0,w1,w2:
  - p0 = w0[23:0]
  - p1 = {w1[15:0], w0[31:24]}
  - p2 = {w2[7:0], w1[31:16]}
  - p3 = w2[31:8]
- Pixel output: registered stage; pix_* hold stable while pix_valid && !pix_ready. Latency from the first R beat to the first pix_valid is at most 4 cycles (word3 needed only for p2). Full throughput is 4 pixels per 3 words; 1 pixel/cycle when the FIFO is non-empty.
- pix_sof is set on pixel index 0; pix_eof on pixel index cfg_pixel_number-1.
- Error handling: rresp != 0 sets rresp_err; the data is still used and the frame continues.
- FIFO full cannot occur by construction. Overflow is an assertion failure in simulation.
- Reset mid-frame returns to IDLE immediately and clears outstanding, reserved and the FIFO.

Test Plan:
- BURST_SIZE=16, pixels=64 (48 words), slave always ready, incrementing bytes 0x00.. -> 3 ARs at base, +0x40, +0x80 with arlen=15; pix_data 0x020100, 0x050403, ...; sof on pixel 0, eof on pixel 63; one frame_done.
- pixels=40 (30 words), BURST_SIZE=16 -> arlen 15 then 13; addresses base and base+0x40; 40 pixels out.
- pix_ready held 0 for 500 cycles, MAX_OUTSTANDING_TR=2, FIFO_DEPTH=64 -> AR stalls once fifo_count + reserved > 48; no rvalid beat lost; pix_data stable throughout.
- rresp=2'b10 on one beat -> rresp_err=1 and frame completes normally; next frame_start clears it.
- cfg_enable dropped after the first AR of 3 -> no further AR; remaining beats drained; busy falls after the last rlast; no frame_done; a new frame afterwards starts clean with sof on the first pixel.
- Simultaneous AR handshake and rlast with outstanding=1 -> outstanding stays 1.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// Frame buffer reader: AXI4 read-master DMA that fetches one frame of packed
// 24-bit RGB (4 pixels per 3 little-endian words) into a word FIFO and
// unpacks it into a pixel stream. Bursts are only issued when the FIFO has
// room for a whole burst on top of the data already promised to the bus.
module frame_buffer_reader #(
    parameter int BURST_SIZE         = 128,
    parameter int MAX_OUTSTANDING_TR = 2,
    parameter int FIFO_DEPTH         = 512
) (
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_start_addr,
    input  logic [25:0] cfg_pixel_number,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic        rresp_err,
    output logic [3:0]  mst_axi_arid,
    output logic [31:0] mst_axi_araddr,
    output logic [7:0]  mst_axi_arlen,
    output logic [2:0]  mst_axi_arsize,
    output logic [1:0]  mst_axi_arburst,
    output logic        mst_axi_arvalid,
    input  logic        mst_axi_arready,
    input  logic [31:0] mst_axi_rdata,
    input  logic [1:0]  mst_axi_rresp,
    input  logic        mst_axi_rlast,
    input  logic        mst_axi_rvalid,
    output logic        mst_axi_rready,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eof
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OST_W = $clog2(MAX_OUTSTANDING_TR + 1);
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH - BURST_SIZE);
    localparam logic [CNT_W-1:0] FIFO_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [OST_W-1:0] OST_MAX      = OST_W'(MAX_OUTSTANDING_TR);
    localparam logic [26:0]      BURST_WORDS  = 27'(BURST_SIZE);
    localparam logic [7:0]       ARLEN_FULL   = 8'(BURST_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              arvalid_q, arvalid_d;
    logic [26:0]       words_left_q, words_left_d;
    logic [OST_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  reserved_q, reserved_d;
    logic [PTR_W-1:0]  fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [PTR_W-1:0]  fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [1:0]        phase_q, phase_d;
    logic [23:0]       prev_word_q, prev_word_d;
    logic [25:0]       pix_total_q, pix_total_d;
    logic [25:0]       pix_emit_q, pix_emit_d;
    logic [23:0]       pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              pix_sof_q, pix_sof_d;
    logic              pix_eof_q, pix_eof_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              rresp_err_q, rresp_err_d;
    logic              rready_q, rready_d;

    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [31:0] fifo_head;
    logic        ar_hs, r_beat, r_last, fifo_wr, fifo_rd;
    logic        credit_ok, active, need_word, can_load, pix_load, pix_accept;
    logic [8:0]  ar_beats;
    logic [26:0] frame_words;
    logic [23:0] unpacked;

    // Handshake qualifiers, credit check and unpacker selection.
    always_comb begin
        ar_hs       = arvalid_q && mst_axi_arready;
        r_beat      = mst_axi_rvalid && rready_q;
        r_last      = r_beat && mst_axi_rlast;
        active      = (state_q == FETCH) || (state_q == DRAIN);
        fifo_wr     = r_beat && active;
        fifo_head   = fifo_mem[fifo_rd_ptr_q];
        ar_beats    = {1'b0, arlen_q} + 9'd1;
        credit_ok   = ({1'b0, fifo_count_q} + {1'b0, reserved_q}) <= CREDIT_LIMIT;
        frame_words = {3'b000, cfg_pixel_number[25:2]} + {2'b00, cfg_pixel_number[25:2], 1'b0};
        need_word   = (phase_q != 2'd3);
        can_load    = active && (pix_emit_q != pix_total_q) && (!need_word || fifo_count_q != '0);
        pix_load    = can_load && (!pix_valid_q || pix_ready);
        fifo_rd     = pix_load && need_word;
        pix_accept  = pix_valid_q && pix_ready;
        unpacked    = '0;
        unique case (phase_q)
            2'd0: unpacked = fifo_head[23:0];
            2'd1: unpacked = {fifo_head[15:0], prev_word_q[23:16]};
            2'd2: unpacked = {fifo_head[7:0], prev_word_q[23:8]};
            default: unpacked = prev_word_q;
        endcase
    end

    // Next-state computation for the FSM, burst bookkeeping, FIFO and pixel stage.
    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arvalid_d     = arvalid_q;
        words_left_d  = words_left_q;
        outstanding_d = outstanding_q;
        reserved_d    = reserved_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_count_d  = fifo_count_q;
        phase_d       = phase_q;
        prev_word_d   = prev_word_q;
        pix_total_d   = pix_total_q;
        pix_emit_d    = pix_emit_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = pix_valid_q;
        pix_sof_d     = pix_sof_q;
        pix_eof_d     = pix_eof_q;
        rresp_err_d   = rresp_err_q;
        rready_d      = 1'b1;
        frame_done_d  = 1'b0;

        if (ar_hs) begin
            araddr_d     = araddr_q + {21'b0, ar_beats, 2'b00};
            words_left_d = words_left_q - {18'b0, ar_beats};
            reserved_d   = reserved_q + CNT_W'(ar_beats);
            arvalid_d    = 1'b0;
        end
        if (ar_hs && !r_last) begin
            outstanding_d = outstanding_q + OST_W'(1);
        end else if (!ar_hs && r_last) begin
            outstanding_d = outstanding_q - OST_W'(1);
        end
        if (r_beat) begin
            reserved_d = reserved_d - CNT_W'(1);
            if (mst_axi_rresp != 2'b00) begin
                rresp_err_d = 1'b1;
            end
        end

        if (fifo_wr) begin
            fifo_wr_ptr_d = fifo_wr_ptr_q + PTR_W'(1);
        end
        if (fifo_rd) begin
            fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_W'(1);
            prev_word_d   = fifo_head[31:8];
        end
        fifo_count_d = fifo_count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

        if (pix_load) begin
            pix_data_d  = unpacked;
            pix_valid_d = 1'b1;
            pix_sof_d   = (pix_emit_q == 26'd0);
            pix_eof_d   = (pix_emit_q == pix_total_q - 26'd1);
            pix_emit_d  = pix_emit_q + 26'd1;
            phase_d     = phase_q + 2'd1;
        end else if (pix_accept) begin
            pix_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_start && cfg_enable) begin
                    state_d       = FETCH;
                    araddr_d      = cfg_start_addr;
                    words_left_d  = frame_words;
                    pix_total_d   = cfg_pixel_number;
                    pix_emit_d    = 26'd0;
                    phase_d       = 2'd0;
                    fifo_wr_ptr_d = '0;
                    fifo_rd_ptr_d = '0;
                    fifo_count_d  = '0;
                    rresp_err_d   = 1'b0;
                end
            end
            FETCH: begin
                if (!cfg_enable) begin
                    state_d = FLUSH;
                end else begin
                    if (ar_hs && words_left_d == 27'd0) begin
                        state_d = DRAIN;
                    end
                    if (!arvalid_q && outstanding_q < OST_MAX && credit_ok && words_left_q != 27'd0) begin
                        arvalid_d = 1'b1;
                        arlen_d   = (words_left_q >= BURST_WORDS) ? ARLEN_FULL : (words_left_q[7:0] - 8'd1);
                    end
                end
            end
            DRAIN: begin
                if (!cfg_enable) begin
                    state_d = FLUSH;
                end else if (pix_accept && pix_eof_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                fifo_wr_ptr_d = '0;
                fifo_rd_ptr_d = '0;
                fifo_count_d  = '0;
                phase_d       = 2'd0;
                pix_valid_d   = 1'b0;
                pix_sof_d     = 1'b0;
                pix_eof_d     = 1'b0;
                if (outstanding_q == '0 && !arvalid_q) begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Register every piece of state; reset aborts any frame in flight.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q       <= IDLE;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            words_left_q  <= '0;
            outstanding_q <= '0;
            reserved_q    <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_count_q  <= '0;
            phase_q       <= '0;
            prev_word_q   <= '0;
            pix_total_q   <= '0;
            pix_emit_q    <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_sof_q     <= 1'b0;
            pix_eof_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            rresp_err_q   <= 1'b0;
            rready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arvalid_q     <= arvalid_d;
            words_left_q  <= words_left_d;
            outstanding_q <= outstanding_d;
            reserved_q    <= reserved_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            phase_q       <= phase_d;
            prev_word_q   <= prev_word_d;
            pix_total_q   <= pix_total_d;
            pix_emit_q    <= pix_emit_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_sof_q     <= pix_sof_d;
            pix_eof_q     <= pix_eof_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            rresp_err_q   <= rresp_err_d;
            rready_q      <= rready_d;
        end
    end

    // Word storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk_sys) begin
        if (fifo_wr) begin
            fifo_mem[fifo_wr_ptr_q] <= mst_axi_rdata;
        end
    end

    // Credits make a full-FIFO write impossible; flag it if it ever happens.
    assert property (@(posedge clk_sys) disable iff (rst_sys)
        !(fifo_wr && !fifo_rd && fifo_count_q == FIFO_FULL));

    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign rresp_err       = rresp_err_q;
    assign mst_axi_arid    = 4'd0;
    assign mst_axi_araddr  = araddr_q;
    assign mst_axi_arlen   = arlen_q;
    assign mst_axi_arsize  = 3'b010;
    assign mst_axi_arburst = 2'b01;
    assign mst_axi_arvalid = arvalid_q;
    assign mst_axi_rready  = rready_q;
    assign pix_data        = pix_data_q;
    assign pix_valid       = pix_valid_q;
    assign pix_sof         = pix_sof_q;
    assign pix_eof         = pix_eof_q;

endmodule
